// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game controller.
package pong_pkg;

    // Width of a board coordinate (ball and paddle positions)
    localparam int BOARD_W = 6;
    // Width of a player score
    localparam int SCORE_W = 4;
    // Largest representable score; scores hold here instead of wrapping
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    typedef enum logic [2:0] {
        IDLE,
        RUNNING,
        POINT,
        SERVE,
        GAME_OVER
    } state_e;

    // Add one point, holding at the top of the score range
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] score);
        if (score == SCORE_W'(SCORE_MAX)) begin
            return score;
        end
        return score + 1'b1;
    endfunction

endpackage

// File: rtl/pong_paddle_hit.sv
// Paddle hit test: the ball row lies within the rows the paddle covers.
// The comparison is widened by one bit so a paddle near the bottom of the
// coordinate range cannot wrap its lower edge back to the top.
module pong_paddle_hit
    import pong_pkg::*;
#(
    parameter int c_PADDLE_HEIGHT = 6
) (
    input  logic [BOARD_W-1:0] ball_y_i,
    input  logic [BOARD_W-1:0] paddle_y_i,
    output logic               hit_o
);

    localparam int EXT_W = BOARD_W + 1;

    logic [EXT_W-1:0] ball_ext;
    logic [EXT_W-1:0] top_ext;
    logic [EXT_W-1:0] bot_ext;

    assign ball_ext = {1'b0, ball_y_i};
    assign top_ext  = {1'b0, paddle_y_i};
    assign bot_ext  = top_ext + EXT_W'(c_PADDLE_HEIGHT - 1);

    assign hit_o = (ball_ext >= top_ext) && (ball_ext <= bot_ext);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-level controller: gates the ball controller via o_Game_Active,
// scores missed returns, and declares the winner.
// Optional feature macro SERVE_DELAY_EN: after a point with no winner, wait
// c_SERVE_DELAY clocks in SERVE and resume play without a start press.
// Without it, play waits in IDLE for the next start press.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int c_GAME_WIDTH    = 40,
    parameter int c_GAME_HEIGHT   = 30,
    parameter int c_PADDLE_HEIGHT = 6,
    parameter int c_SCORE_LIMIT   = 9,
    parameter int c_SERVE_DELAY   = 25000000
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Start,
    input  logic [BOARD_W-1:0] i_Ball_X,
    input  logic [BOARD_W-1:0] i_Ball_Y,
    input  logic [BOARD_W-1:0] i_Paddle_Y_P1,
    input  logic [BOARD_W-1:0] i_Paddle_Y_P2,
    output logic               o_Game_Active,
    output logic [SCORE_W-1:0] o_P1_Score,
    output logic [SCORE_W-1:0] o_P2_Score,
    output logic               o_Game_Over,
    output logic               o_Winner
);

    // Configuration range checks
    if (c_GAME_WIDTH < 2 || c_GAME_WIDTH > (1 << BOARD_W)) begin : g_bad_width
        $error("pong_game_ctrl: c_GAME_WIDTH out of range");
    end
    if (c_GAME_HEIGHT < c_PADDLE_HEIGHT || c_GAME_HEIGHT > (1 << BOARD_W)) begin : g_bad_height
        $error("pong_game_ctrl: c_GAME_HEIGHT out of range");
    end
    if (c_PADDLE_HEIGHT < 1) begin : g_bad_paddle
        $error("pong_game_ctrl: c_PADDLE_HEIGHT must be at least 1");
    end
    if (c_SCORE_LIMIT < 1 || c_SCORE_LIMIT > SCORE_MAX) begin : g_bad_limit
        $error("pong_game_ctrl: c_SCORE_LIMIT out of range");
    end
    if (c_SERVE_DELAY < 1) begin : g_bad_delay
        $error("pong_game_ctrl: c_SERVE_DELAY must be at least 1");
    end

    localparam logic [SCORE_W-1:0] LIMIT    = SCORE_W'(c_SCORE_LIMIT);
    localparam logic [BOARD_W-1:0] P2_GOAL  = BOARD_W'(c_GAME_WIDTH - 1);

    state_e             state_q, state_d;
    logic               start_q;
    logic               start_pulse;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic               active_q, active_d;
    logic               over_q, over_d;
    logic               winner_q, winner_d;
    logic               hit_p1, hit_p2;
    logic               miss_p1, miss_p2;

`ifdef SERVE_DELAY_EN
    localparam int SERVE_CNT_W = (c_SERVE_DELAY > 1) ? $clog2(c_SERVE_DELAY) : 1;
    localparam logic [SERVE_CNT_W-1:0] SERVE_LAST = SERVE_CNT_W'(c_SERVE_DELAY - 1);

    logic [SERVE_CNT_W-1:0] serve_cnt_q, serve_cnt_d;
`endif

    pong_paddle_hit #(
        .c_PADDLE_HEIGHT(c_PADDLE_HEIGHT)
    ) u_hit_p1 (
        .ball_y_i  (i_Ball_Y),
        .paddle_y_i(i_Paddle_Y_P1),
        .hit_o     (hit_p1)
    );

    pong_paddle_hit #(
        .c_PADDLE_HEIGHT(c_PADDLE_HEIGHT)
    ) u_hit_p2 (
        .ball_y_i  (i_Ball_Y),
        .paddle_y_i(i_Paddle_Y_P2),
        .hit_o     (hit_p2)
    );

    // A miss is only possible at the goal column of that player
    assign miss_p1     = (i_Ball_X == '0) && !hit_p1;
    assign miss_p2     = (i_Ball_X == P2_GOAL) && !hit_p2;
    assign start_pulse = i_Start & ~start_q;

    // Remember last start level so a held switch starts only once
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            start_q <= 1'b0;
        end else begin
            start_q <= i_Start;
        end
    end

    // Next state, scores and registered outputs
    always_comb begin
        state_d    = state_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        winner_d   = winner_q;
`ifdef SERVE_DELAY_EN
        serve_cnt_d = serve_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    state_d = RUNNING;
                end
            end
            RUNNING: begin
                if (miss_p1) begin
                    p2_score_d = score_inc(p2_score_q);
                    state_d    = POINT;
                end else if (miss_p2) begin
                    p1_score_d = score_inc(p1_score_q);
                    state_d    = POINT;
                end
            end
            POINT: begin
                if (p1_score_q == LIMIT || p2_score_q == LIMIT) begin
                    state_d  = GAME_OVER;
                    winner_d = (p2_score_q == LIMIT);
                end else begin
`ifdef SERVE_DELAY_EN
                    state_d     = SERVE;
                    serve_cnt_d = '0;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef SERVE_DELAY_EN
            SERVE: begin
                if (serve_cnt_q == SERVE_LAST) begin
                    state_d = RUNNING;
                end else begin
                    serve_cnt_d = serve_cnt_q + 1'b1;
                end
            end
`endif
            GAME_OVER: begin
                if (start_pulse) begin
                    p1_score_d = '0;
                    p2_score_d = '0;
                    state_d    = RUNNING;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs follow the state being entered so they are registered with it
        active_d = (state_d == RUNNING);
        over_d   = (state_d == GAME_OVER);
    end

    // State and output registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= IDLE;
            p1_score_q <= '0;
            p2_score_q <= '0;
            active_q   <= 1'b0;
            over_q     <= 1'b0;
            winner_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
            active_q   <= active_d;
            over_q     <= over_d;
            winner_q   <= winner_d;
        end
    end

`ifdef SERVE_DELAY_EN
    // Serve hold counter
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            serve_cnt_q <= '0;
        end else begin
            serve_cnt_q <= serve_cnt_d;
        end
    end
`endif

    assign o_Game_Active = active_q;
    assign o_P1_Score    = p1_score_q;
    assign o_P2_Score    = p2_score_q;
    assign o_Game_Over   = over_q;
    assign o_Winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed testbench for pong_game_ctrl (default build and SERVE_DELAY_EN build).
module tb_pong_game_ctrl;

    localparam int LIMIT = 9;
`ifdef SERVE_DELAY_EN
    localparam int HOLD = 5;
`else
    localparam int HOLD = 100;
`endif

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b1;
    logic       i_Start = 1'b0;
    logic [5:0] i_Ball_X = 6'd20;
    logic [5:0] i_Ball_Y = 6'd15;
    logic [5:0] i_Paddle_Y_P1 = 6'd12;
    logic [5:0] i_Paddle_Y_P2 = 6'd12;
    logic       o_Game_Active;
    logic [3:0] o_P1_Score;
    logic [3:0] o_P2_Score;
    logic       o_Game_Over;
    logic       o_Winner;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int exp_p1 = 0;
    int exp_p2 = 0;

    pong_game_ctrl #(
        .c_GAME_WIDTH   (40),
        .c_GAME_HEIGHT  (30),
        .c_PADDLE_HEIGHT(6),
        .c_SCORE_LIMIT  (LIMIT),
        .c_SERVE_DELAY  (10)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Start      (i_Start),
        .i_Ball_X     (i_Ball_X),
        .i_Ball_Y     (i_Ball_Y),
        .i_Paddle_Y_P1(i_Paddle_Y_P1),
        .i_Paddle_Y_P2(i_Paddle_Y_P2),
        .o_Game_Active(o_Game_Active),
        .o_P1_Score   (o_P1_Score),
        .o_P2_Score   (o_P2_Score),
        .o_Game_Over  (o_Game_Over),
        .o_Winner     (o_Winner)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic start_game();
        i_Start = 1'b1;
        tick(1);
        i_Start = 1'b0;
        cmp_cnt++; if (o_Game_Active !== 1'b1) begin err_cnt++; $display("FAIL start_game_active: got %b want 1", o_Game_Active); end
    endtask

    // Return to play after a non-winning point
    task automatic resume();
`ifdef SERVE_DELAY_EN
        int n = 0;
        while (o_Game_Active !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        cmp_cnt++; if (o_Game_Active !== 1'b1) begin err_cnt++; $display("FAIL resume_auto_serve: active=%b after %0d cycles want 1", o_Game_Active, n); end
`else
        start_game();
`endif
    endtask

    task automatic p1_miss();
        i_Paddle_Y_P1 = 6'd8; i_Ball_X = 6'd0; i_Ball_Y = 6'd16;
        tick(1);
        exp_p2++;
        cmp_cnt++; if (o_P2_Score !== 4'(exp_p2)) begin err_cnt++; $display("FAIL p1_miss_p2_score: got %0d want %0d", o_P2_Score, exp_p2); end
        cmp_cnt++; if (o_P1_Score !== 4'(exp_p1)) begin err_cnt++; $display("FAIL p1_miss_p1_score: got %0d want %0d", o_P1_Score, exp_p1); end
        cmp_cnt++; if (o_Game_Active !== 1'b0) begin err_cnt++; $display("FAIL p1_miss_active: got %b want 0", o_Game_Active); end
        i_Ball_X = 6'd20; i_Ball_Y = 6'd15;
        tick(1);
    endtask

    task automatic p2_miss();
        i_Paddle_Y_P2 = 6'd5; i_Ball_X = 6'd39; i_Ball_Y = 6'd0;
        tick(1);
        exp_p1++;
        cmp_cnt++; if (o_P1_Score !== 4'(exp_p1)) begin err_cnt++; $display("FAIL p2_miss_p1_score: got %0d want %0d", o_P1_Score, exp_p1); end
        cmp_cnt++; if (o_P2_Score !== 4'(exp_p2)) begin err_cnt++; $display("FAIL p2_miss_p2_score: got %0d want %0d", o_P2_Score, exp_p2); end
        cmp_cnt++; if (o_Game_Active !== 1'b0) begin err_cnt++; $display("FAIL p2_miss_active: got %b want 0", o_Game_Active); end
        i_Ball_X = 6'd20; i_Ball_Y = 6'd15;
        tick(1);
    endtask

    task automatic test_reset();
        #2 i_Rst_L = 1'b0;
        tick(2);
        cmp_cnt++; if (o_Game_Active !== 1'b0) begin err_cnt++; $display("FAIL reset_active: got %b want 0", o_Game_Active); end
        cmp_cnt++; if (o_P1_Score !== 4'd0 || o_P2_Score !== 4'd0) begin err_cnt++; $display("FAIL reset_scores: got %0d/%0d want 0/0", o_P1_Score, o_P2_Score); end
        cmp_cnt++; if (o_Game_Over !== 1'b0) begin err_cnt++; $display("FAIL reset_over: got %b want 0", o_Game_Over); end
        cmp_cnt++; if (o_Winner !== 1'b0) begin err_cnt++; $display("FAIL reset_winner: got %b want 0", o_Winner); end
        i_Rst_L = 1'b1;
        tick(3);
        cmp_cnt++; if (o_Game_Active !== 1'b0) begin err_cnt++; $display("FAIL idle_no_start_active: got %b want 0", o_Game_Active); end
    endtask

    task automatic test_start();
        i_Start = 1'b1;
        tick(1);
        cmp_cnt++; if (o_Game_Active !== 1'b1) begin err_cnt++; $display("FAIL start_edge_active: got %b want 1", o_Game_Active); end
        cmp_cnt++; if (o_P1_Score !== 4'd0 || o_P2_Score !== 4'd0) begin err_cnt++; $display("FAIL start_scores: got %0d/%0d want 0/0", o_P1_Score, o_P2_Score); end
        tick(3);
        cmp_cnt++; if (o_Game_Active !== 1'b1) begin err_cnt++; $display("FAIL start_held_active: got %b want 1", o_Game_Active); end
        i_Start = 1'b0;
        tick(1);
    endtask

    task automatic test_hit_miss();
        i_Paddle_Y_P1 = 6'd10; i_Ball_X = 6'd0; i_Ball_Y = 6'd12;
        tick(3);
        cmp_cnt++; if (o_Game_Active !== 1'b1) begin err_cnt++; $display("FAIL p1_hit_active: got %b want 1", o_Game_Active); end
        cmp_cnt++; if (o_P2_Score !== 4'd0) begin err_cnt++; $display("FAIL p1_hit_score: got %0d want 0", o_P2_Score); end
        i_Ball_Y = 6'd15;
        tick(2);
        cmp_cnt++; if (o_Game_Active !== 1'b1) begin err_cnt++; $display("FAIL p1_hit_last_row: got %b want 1", o_Game_Active); end
        i_Paddle_Y_P2 = 6'd60; i_Ball_X = 6'd39; i_Ball_Y = 6'd63;
        tick(2);
        cmp_cnt++; if (o_Game_Active !== 1'b1) begin err_cnt++; $display("FAIL p2_hit_wide_active: got %b want 1", o_Game_Active); end
        cmp_cnt++; if (o_P1_Score !== 4'd0) begin err_cnt++; $display("FAIL p2_hit_wide_score: got %0d want 0", o_P1_Score); end
        i_Ball_X = 6'd0; i_Ball_Y = 6'd16;
        tick(1);
        exp_p2 = 1;
        cmp_cnt++; if (o_P2_Score !== 4'd1) begin err_cnt++; $display("FAIL p1_miss_first_score: got %0d want 1", o_P2_Score); end
        cmp_cnt++; if (o_Game_Active !== 1'b0) begin err_cnt++; $display("FAIL p1_miss_first_active: got %b want 0", o_Game_Active); end
        i_Ball_X = 6'd20; i_Ball_Y = 6'd15; i_Paddle_Y_P1 = 6'd12; i_Paddle_Y_P2 = 6'd12;
        tick(1);
        cmp_cnt++; if (o_Game_Active !== 1'b0 || o_Game_Over !== 1'b0) begin err_cnt++; $display("FAIL after_point: active=%b over=%b want 0/0", o_Game_Active, o_Game_Over); end
    endtask

    task automatic test_hold_miss();
        resume();
        i_Paddle_Y_P2 = 6'd5; i_Ball_X = 6'd39; i_Ball_Y = 6'd0;
        tick(HOLD);
        exp_p1 = 1;
        cmp_cnt++; if (o_P1_Score !== 4'd1) begin err_cnt++; $display("FAIL hold_miss_once: got %0d want 1", o_P1_Score); end
        cmp_cnt++; if (o_P2_Score !== 4'(exp_p2)) begin err_cnt++; $display("FAIL hold_miss_p2: got %0d want %0d", o_P2_Score, exp_p2); end
        cmp_cnt++; if (o_Game_Active !== 1'b0) begin err_cnt++; $display("FAIL hold_miss_active: got %b want 0", o_Game_Active); end
        i_Ball_X = 6'd20; i_Ball_Y = 6'd15;
        tick(1);
    endtask

    task automatic test_no_retrigger();
        resume();
        i_Start = 1'b1;
        tick(2);
        cmp_cnt++; if (o_Game_Active !== 1'b1) begin err_cnt++; $display("FAIL start_in_running: got %b want 1", o_Game_Active); end
        cmp_cnt++; if (o_P1_Score !== 4'(exp_p1) || o_P2_Score !== 4'(exp_p2)) begin err_cnt++; $display("FAIL start_in_running_scores: got %0d/%0d want %0d/%0d", o_P1_Score, o_P2_Score, exp_p1, exp_p2); end
        p1_miss();
        tick(3);
        cmp_cnt++; if (o_Game_Active !== 1'b0) begin err_cnt++; $display("FAIL held_start_retrigger: got %b want 0", o_Game_Active); end
        i_Start = 1'b0;
        tick(1);
    endtask

    task automatic test_game_over();
        resume();
        while (exp_p2 < LIMIT) begin
            p1_miss();
            if (exp_p2 < LIMIT) resume();
        end
        cmp_cnt++; if (o_Game_Over !== 1'b1) begin err_cnt++; $display("FAIL game_over_flag: got %b want 1", o_Game_Over); end
        cmp_cnt++; if (o_Winner !== 1'b1) begin err_cnt++; $display("FAIL game_over_winner: got %b want 1", o_Winner); end
        tick(3);
        cmp_cnt++; if (o_Game_Over !== 1'b1 || o_Game_Active !== 1'b0) begin err_cnt++; $display("FAIL game_over_hold: over=%b active=%b want 1/0", o_Game_Over, o_Game_Active); end
        i_Start = 1'b1;
        tick(1);
        exp_p1 = 0; exp_p2 = 0;
        cmp_cnt++; if (o_P1_Score !== 4'd0 || o_P2_Score !== 4'd0) begin err_cnt++; $display("FAIL restart_scores: got %0d/%0d want 0/0", o_P1_Score, o_P2_Score); end
        cmp_cnt++; if (o_Game_Active !== 1'b1 || o_Game_Over !== 1'b0) begin err_cnt++; $display("FAIL restart_flags: active=%b over=%b want 1/0", o_Game_Active, o_Game_Over); end
        i_Start = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid();
        repeat (4) begin p1_miss(); resume(); end
        repeat (3) begin p2_miss(); resume(); end
        cmp_cnt++; if (o_P1_Score !== 4'd3 || o_P2_Score !== 4'd4) begin err_cnt++; $display("FAIL pre_reset_scores: got %0d/%0d want 3/4", o_P1_Score, o_P2_Score); end
        #3 i_Rst_L = 1'b0;
        #1;
        exp_p1 = 0; exp_p2 = 0;
        cmp_cnt++; if (o_Game_Active !== 1'b0) begin err_cnt++; $display("FAIL async_reset_active: got %b want 0", o_Game_Active); end
        cmp_cnt++; if (o_P1_Score !== 4'd0 || o_P2_Score !== 4'd0) begin err_cnt++; $display("FAIL async_reset_scores: got %0d/%0d want 0/0", o_P1_Score, o_P2_Score); end
        cmp_cnt++; if (o_Game_Over !== 1'b0 || o_Winner !== 1'b0) begin err_cnt++; $display("FAIL async_reset_flags: over=%b winner=%b want 0/0", o_Game_Over, o_Winner); end
        tick(2);
        i_Rst_L = 1'b1;
        tick(3);
        cmp_cnt++; if (o_Game_Active !== 1'b0) begin err_cnt++; $display("FAIL post_reset_idle: got %b want 0", o_Game_Active); end
    endtask

`ifdef SERVE_DELAY_EN
    task automatic test_serve();
        int lows;
        start_game();
        i_Paddle_Y_P1 = 6'd8; i_Ball_X = 6'd0; i_Ball_Y = 6'd16;
        tick(1);
        exp_p2++;
        lows = (o_Game_Active == 1'b0) ? 1 : 0;
        i_Ball_X = 6'd20; i_Ball_Y = 6'd15;
        for (int i = 0; i < 50 && o_Game_Active !== 1'b1; i++) begin
            tick(1);
            if (o_Game_Active == 1'b0) lows++;
        end
        cmp_cnt++; if (lows != 11) begin err_cnt++; $display("FAIL serve_low_cycles: got %0d want 11", lows); end
        cmp_cnt++; if (o_Game_Active !== 1'b1) begin err_cnt++; $display("FAIL serve_auto_active: got %b want 1", o_Game_Active); end
        cmp_cnt++; if (o_P2_Score !== 4'(exp_p2)) begin err_cnt++; $display("FAIL serve_score: got %0d want %0d", o_P2_Score, exp_p2); end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_hit_miss();
        test_hold_miss();
`ifndef SERVE_DELAY_EN
        test_no_retrigger();
`endif
        test_game_over();
        test_reset_mid();
`ifdef SERVE_DELAY_EN
        test_serve();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
